decode_queue: RTL and testbench

Buffered, pipelined RV32I instruction decode stage with optional RV32M decode. Accepts fetched {pc, ir} pairs through a valid/ready handshake into a DEPTH-entry queue, decodes the queue head into a registered output bundle, and presents it to the execute stage through a second valid/ready handshake. Supports flush on branch redirect, and flags illegal encodings instead of passing garbage downstream.

---
 rtl/decode_queue_if.sv | 39 +++
 rtl/decode_queue.sv | 276 +++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshakes of the decode queue, bundled for port lists.
// A transfer happens on a rising edge where valid && ready; the sender holds its payload until then.
interface decode_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_ir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  srcreg1_num;
  logic [4:0]  srcreg2_num;
  logic [4:0]  dstreg_num;
  logic [31:0] imm;
  logic [3:0]  alucode;
  logic        using_r2;
  logic        using_pc;
  logic        write_reg;
  logic [2:0]  info_load;
  logic [1:0]  info_store;
  logic [2:0]  info_branch;
  logic        muldiv;
  logic [2:0]  muldiv_op;
  logic        illegal;

  modport slave (
    input  in_valid, in_pc, in_ir, out_ready,
    output in_ready, out_valid, out_pc, srcreg1_num, srcreg2_num, dstreg_num, imm,
           alucode, using_r2, using_pc, write_reg, info_load, info_store, info_branch,
           muldiv, muldiv_op, illegal
  );

  modport master (
    output in_valid, in_pc, in_ir, out_ready,
    input  in_ready, out_valid, out_pc, srcreg1_num, srcreg2_num, dstreg_num, imm,
           alucode, using_r2, using_pc, write_reg, info_load, info_store, info_branch,
           muldiv, muldiv_op, illegal
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I(+M) decode stage: DEPTH-entry fetch queue feeding a registered decoded bundle.
// Illegal encodings still produce a bundle, flagged and with all side effects suppressed.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  decode_queue_if.slave          io,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_UNUSED = 4'd15;
  // Load/store/branch kinds reuse funct3. Nine branch kinds share three bits: JAL/JALR take
  // the two funct3 codes no branch uses, and NOTBRANCH aliases Beq (a BEQ has using_pc=1, write_reg=0).
  localparam logic [2:0] LD_NONE = 3'd7;
  localparam logic [1:0] ST_NONE = 2'd3;
  localparam logic [2:0] BR_JAL = 3'd2, BR_JALR = 3'd3, BR_NONE = 3'd0;

  localparam logic [6:0] OPC_OP = 7'h33, OPC_OPIMM = 7'h13, OPC_LUI = 7'h37, OPC_AUIPC = 7'h17,
                         OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_BRANCH = 7'h63,
                         OPC_JAL = 7'h6f, OPC_JALR = 7'h67;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  srcreg1;
    logic [4:0]  srcreg2;
    logic [4:0]  dstreg;
    logic [31:0] imm;
    logic [3:0]  alucode;
    logic        using_r2;
    logic        using_pc;
    logic        write_reg;
    logic [2:0]  info_load;
    logic [1:0]  info_store;
    logic [2:0]  info_branch;
    logic        muldiv;
    logic [2:0]  muldiv_op;
    logic        illegal;
  } bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } entry_t;

  function automatic bundle_t reset_bundle();
    bundle_t b;
    b             = '0;
    b.alucode     = ALU_UNUSED;
    b.info_load   = LD_NONE;
    b.info_store  = ST_NONE;
    b.info_branch = BR_NONE;
    return b;
  endfunction

  function automatic logic [3:0] alu_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  bundle_t       out_q, out_d, dec;
  logic          push, pop, bad;

  entry_t      head;
  logic [31:0] ir, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;

  assign head  = mem_q[rd_ptr_q];
  assign ir    = head.ir;
  assign opc   = ir[6:0];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign f7    = ir[31:25];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    dec    = reset_bundle();
    dec.pc = head.pc;
    bad    = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.srcreg1   = rs1;
        dec.srcreg2   = rs2;
        dec.dstreg    = rd;
        dec.using_r2  = 1'b1;
        dec.write_reg = 1'b1;
        case (f7)
          7'b0000000: dec.alucode = alu_f3(f3);
          7'b0100000: begin
            if (f3 == 3'd0)      dec.alucode = ALU_SUB;
            else if (f3 == 3'd5) dec.alucode = ALU_SRA;
            else                 bad = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M) begin
              dec.muldiv    = 1'b1;
              dec.muldiv_op = f3;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.srcreg1   = rs1;
        dec.dstreg    = rd;
        dec.write_reg = 1'b1;
        dec.imm       = imm_i;
        dec.alucode   = alu_f3(f3);
        // Shifts carry a 5-bit shamt; funct7 selects SRA and must otherwise be zero.
        if (f3 == 3'd1 || f3 == 3'd5) begin
          dec.imm = {27'd0, ir[24:20]};
          if (f3 == 3'd5 && f7 == 7'b0100000) dec.alucode = ALU_SRA;
          else if (f7 != 7'd0)                bad = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.dstreg    = rd;
        dec.write_reg = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.dstreg    = rd;
        dec.write_reg = 1'b1;
        dec.imm       = imm_u;
        dec.alucode   = ALU_ADD;
        dec.using_pc  = 1'b1;
      end
      OPC_LOAD: begin
        dec.srcreg1   = rs1;
        dec.dstreg    = rd;
        dec.write_reg = 1'b1;
        dec.imm       = imm_i;
        dec.alucode   = ALU_ADD;
        dec.info_load = f3;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) bad = 1'b1;
      end
      OPC_STORE: begin
        dec.srcreg1    = rs1;
        dec.srcreg2    = rs2;
        dec.imm        = imm_s;
        dec.alucode    = ALU_ADD;
        dec.info_store = f3[1:0];
        if (f3 > 3'd2) bad = 1'b1;
      end
      OPC_BRANCH: begin
        dec.srcreg1     = rs1;
        dec.srcreg2     = rs2;
        dec.imm         = imm_b;
        dec.alucode     = ALU_ADD;
        dec.using_pc    = 1'b1;
        dec.info_branch = f3;
        if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
      end
      OPC_JAL: begin
        dec.dstreg      = rd;
        dec.write_reg   = 1'b1;
        dec.imm         = imm_j;
        dec.alucode     = ALU_ADD;
        dec.using_pc    = 1'b1;
        dec.info_branch = BR_JAL;
      end
      OPC_JALR: begin
        dec.srcreg1     = rs1;
        dec.dstreg      = rd;
        dec.write_reg   = 1'b1;
        dec.imm         = imm_i;
        dec.alucode     = ALU_ADD;
        dec.info_branch = BR_JALR;
        if (f3 != 3'd0) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = reset_bundle();
      dec.pc      = head.pc;
      dec.illegal = 1'b1;
    end
  end

  assign io.in_ready = (count_q < CW'(DEPTH)) && !flush;

  always_comb begin
    push        = io.in_valid && io.in_ready;
    pop         = (count_q != '0) && (!out_valid_q || io.out_ready);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: io.in_pc, ir: io.in_ir};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        out_d       = dec;
        out_valid_d = 1'b1;
      end else if (io.out_ready) begin
        out_valid_d = 1'b0;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= reset_bundle();
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign count          = count_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_pc      = out_q.pc;
  assign io.srcreg1_num = out_q.srcreg1;
  assign io.srcreg2_num = out_q.srcreg2;
  assign io.dstreg_num  = out_q.dstreg;
  assign io.imm         = out_q.imm;
  assign io.alucode     = out_q.alucode;
  assign io.using_r2    = out_q.using_r2;
  assign io.using_pc    = out_q.using_pc;
  assign io.write_reg   = out_q.write_reg;
  assign io.info_load   = out_q.info_load;
  assign io.info_store  = out_q.info_store;
  assign io.info_branch = out_q.info_branch;
  assign io.muldiv      = out_q.muldiv;
  assign io.muldiv_op   = out_q.muldiv_op;
  assign io.illegal     = out_q.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (ENABLE_M=0 and 1) share one stimulus stream and are
// checked against an occupancy model plus a table-driven RV32I/M decoder.
module tb_decode_queue;
  localparam int DEPTH = 4;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd2, A_SLTU = 4'd3, A_AND = 4'd4,
                         A_OR = 4'd5, A_XOR = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9,
                         A_UNUSED = 4'd15;
  localparam logic [2:0] L_NONE = 3'd7, B_JAL = 3'd2, B_JALR = 3'd3, B_NONE = 3'd0;
  localparam logic [1:0] S_NONE = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  s1, s2, d;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        r2, upc, wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [2:0]  br;
    logic        md;
    logic [2:0]  mop;
    logic        ill;
  } bundle_t;
  localparam int BW = $bits(bundle_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_ir = '0;
  logic [$clog2(DEPTH):0] count0, count1;
  bundle_t act0, act1;

  decode_queue_if if0();
  decode_queue_if if1();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_pc = in_pc;        assign if1.in_pc = in_pc;
  assign if0.in_ir = in_ir;        assign if1.in_ir = in_ir;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .io(if0), .count(count0));
  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .io(if1), .count(count1));

  assign act0 = {if0.out_pc, if0.srcreg1_num, if0.srcreg2_num, if0.dstreg_num, if0.imm,
                 if0.alucode, if0.using_r2, if0.using_pc, if0.write_reg, if0.info_load,
                 if0.info_store, if0.info_branch, if0.muldiv, if0.muldiv_op, if0.illegal};
  assign act1 = {if1.out_pc, if1.srcreg1_num, if1.srcreg2_num, if1.dstreg_num, if1.imm,
                 if1.alucode, if1.using_r2, if1.using_pc, if1.write_reg, if1.info_load,
                 if1.info_store, if1.info_branch, if1.muldiv, if1.muldiv_op, if1.illegal};

  always #5 clk = ~clk;

  // ---------------- reference decoder ----------------
  logic [3:0] alu_tbl [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  logic [7:0] ld_ok = 8'b0011_0111;
  logic [7:0] st_ok = 8'b0000_0111;
  logic [7:0] br_ok = 8'b1111_0011;

  function automatic bundle_t idle_bundle();
    bundle_t b;
    b = '0; b.alu = A_UNUSED; b.ld = L_NONE; b.st = S_NONE; b.br = B_NONE;
    return b;
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] pc, input logic [31:0] ir,
                                         input bit en_m);
    bundle_t b;
    bit ok;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm, shamt;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25];
    i_imm = 32'($signed(ir) >>> 20);
    s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    u_imm = ir & 32'hffff_f000;
    shamt = 32'(ir[24:20]);
    b = idle_bundle(); b.pc = pc; ok = 1'b1;
    if (op == 7'h33) begin
      b.s1 = ir[19:15]; b.s2 = ir[24:20]; b.d = ir[11:7]; b.r2 = 1; b.wr = 1;
      if (f7 == 7'h00) b.alu = alu_tbl[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) b.alu = A_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) b.alu = A_SRA;
      else if (f7 == 7'h01 && en_m) begin b.md = 1; b.mop = f3; end
      else ok = 1'b0;
    end else if (op == 7'h13) begin
      b.s1 = ir[19:15]; b.d = ir[11:7]; b.wr = 1; b.alu = alu_tbl[f3]; b.imm = i_imm;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        b.imm = shamt;
        if (f3 == 3'd5 && f7 == 7'h20) b.alu = A_SRA;
        else if (f7 != 7'h00) ok = 1'b0;
      end
    end else if (op == 7'h37) begin
      b.d = ir[11:7]; b.wr = 1; b.imm = u_imm;
    end else if (op == 7'h17) begin
      b.d = ir[11:7]; b.wr = 1; b.imm = u_imm; b.alu = A_ADD; b.upc = 1;
    end else if (op == 7'h03) begin
      b.s1 = ir[19:15]; b.d = ir[11:7]; b.wr = 1; b.imm = i_imm; b.alu = A_ADD; b.ld = f3;
      ok = ld_ok[f3];
    end else if (op == 7'h23) begin
      b.s1 = ir[19:15]; b.s2 = ir[24:20]; b.imm = s_imm; b.alu = A_ADD; b.st = f3[1:0];
      ok = st_ok[f3];
    end else if (op == 7'h63) begin
      b.s1 = ir[19:15]; b.s2 = ir[24:20]; b.imm = b_imm; b.alu = A_ADD; b.upc = 1; b.br = f3;
      ok = br_ok[f3];
    end else if (op == 7'h6f) begin
      b.d = ir[11:7]; b.wr = 1; b.imm = j_imm; b.alu = A_ADD; b.upc = 1; b.br = B_JAL;
    end else if (op == 7'h67) begin
      b.s1 = ir[19:15]; b.d = ir[11:7]; b.wr = 1; b.imm = i_imm; b.alu = A_ADD; b.br = B_JALR;
      ok = (f3 == 3'd0);
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      b = idle_bundle(); b.pc = pc; b.ill = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [6:0] ops [10];
    int sel, k;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h33};
    r = $urandom();
    sel = $urandom_range(0, 11);
    if (sel < 10) r[6:0] = ops[sel];
    k = $urandom_range(0, 3);
    if (k == 0) r[31:25] = 7'h00;
    else if (k == 1) r[31:25] = 7'h20;
    else if (k == 2) r[31:25] = 7'h01;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp0_q[$];
  logic [BW-1:0] exp1_q[$];
  int  m_cnt = 0;
  bit  m_ov = 1'b0;
  bit  after_rst = 1'b0;
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] mc;
    bit p_push, p_pop;
    mc = m_cnt[2:0];
    chk("in_ready", {if0.in_ready, if1.in_ready}, {2{(m_cnt < DEPTH) && !flush}});
    chk("count", {count0, count1}, {mc, mc});
    chk("out_valid", {if0.out_valid, if1.out_valid}, {m_ov, m_ov});
    if (after_rst) begin
      chk("reset_bundle_m0", act0, idle_bundle());
      chk("reset_bundle_m1", act1, idle_bundle());
    end
    if (if0.out_valid || if1.out_valid) begin
      chk("expected_available", exp0_q.size() != 0, 1'b1);
      if (exp0_q.size() != 0) begin
        chk("bundle_m0", act0, exp0_q[0]);
        chk("bundle_m1", act1, exp1_q[0]);
      end
    end
    // advance the model across the coming rising edge
    after_rst = rst;
    if (rst || flush) begin
      exp0_q.delete(); exp1_q.delete();
      m_cnt = 0; m_ov = 1'b0;
    end else begin
      p_push = in_valid && if0.in_ready;
      p_pop  = (m_cnt > 0) && (!m_ov || out_ready);
      if (m_ov && out_ready && exp0_q.size() != 0) begin
        void'(exp0_q.pop_front());
        void'(exp1_q.pop_front());
      end
      if (p_push) begin
        exp0_q.push_back(ref_decode(in_pc, in_ir, 1'b0));
        exp1_q.push_back(ref_decode(in_pc, in_ir, 1'b1));
      end
      m_cnt = m_cnt + int'(p_push) - int'(p_pop);
      if (p_pop) m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] ir, input int max_cyc,
                       output bit acc);
    acc = 1'b0;
    in_valid = 1'b1; in_pc = pc; in_ir = ir;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clk);
      acc = if0.in_ready;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic push_must(input logic [31:0] pc, input logic [31:0] ir);
    bit acc;
    offer(pc, ir, 50, acc);
    chk("push_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp0_q.size() != 0; i++) tick();
    tick();
    chk("drained", exp0_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    repeat (3) tick();
    rst = 1'b0;

    out_ready = 1'b1;
    push_must(32'h100, 32'h00b50633);
    drain();

    out_ready = 1'b0;
    push_must(32'h200, 32'hfff00093);
    push_must(32'h204, 32'h0050a113);
    push_must(32'h208, 32'h0020a423);
    push_must(32'h20c, 32'hfe2084e3);
    push_must(32'h210, 32'h008100e7);
    offer(32'h214, 32'h010000ef, 4, acc);
    chk("full_blocks_push", acc, 1'b0);
    drain();

    out_ready = 1'b1;
    push_must(32'h300, 32'h02b50633);
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_must(32'h400 + 32'(4 * i), rand_ir());
    in_valid = 1'b1; in_pc = 32'h4f0; in_ir = 32'h00000013; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) tick();
    drain();

    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_must(32'h500 + 32'(4 * i), rand_ir());
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_must(32'h600 + 32'(4 * i), rand_ir());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = {$urandom_range(0, 32'h3fff), 2'b00};
      in_ir     = rand_ir();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 200) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
